// File: rtl/ex_pkg.sv
// ex_pkg: ALU opcode, multiplier FSM state and MUL opcode definitions for ex_stage
package ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010
  } aluop_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} ex_state_t;
  localparam logic [3:0] MUL_OP = 4'b1010;
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier (IDLE/BUSY/DONE), low WIDTH bits of a*b
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(MUL_CYCLES);
  ex_state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state == IDLE ? (start ? BUSY : IDLE) :
                state == BUSY ? (cnt == CW'(MUL_CYCLES - 1) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? state_nxt : IDLE;
  always_ff @(posedge clk)
    if (!rst) begin
      {a_r, b_r, product} <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
      product <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      product <= b_r[0] ? product + a_r : product;
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with ALU, shift-add MUL and EX/MEM regs; EX_FWD_EN enables operand forwarding
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ALUOP_IN,
  input  logic             ALUSRC_IN,
  input  logic             REGWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             MEMWRITE_IN,
  input  logic             MEMREAD_IN,
  input  logic [4:0]       ARS1_IN,
  input  logic [4:0]       ARS2_IN,
  input  logic [4:0]       ARD_IN,
  input  logic [WIDTH-1:0] RS1_IN,
  input  logic [WIDTH-1:0] RS2_IN,
  input  logic [WIDTH-1:0] IMMEDIATE_IN,
  input  logic             MEMWB_REGWRITE,
  input  logic [4:0]       MEMWB_ARD,
  input  logic [WIDTH-1:0] MEMWB_RESULT,
  output logic [WIDTH-1:0] ALU_RESULT_OUT,
  output logic [WIDTH-1:0] STORE_DATA_OUT,
  output logic [4:0]       ARD_OUT,
  output logic             REGWRITE_OUT,
  output logic             MEMTOREG_OUT,
  output logic             MEMWRITE_OUT,
  output logic             MEMREAD_OUT,
  output logic             STALL
);
  logic [WIDTH-1:0] a_op, rs2_f, b_op, alu, product, sd_q;
  logic [8:0] ctl_in, ctl_q;
  logic busy, done, start;
`ifdef EX_FWD_EN
  assign a_op = REGWRITE_OUT && ARD_OUT != 5'd0 && ARD_OUT == ARS1_IN ? ALU_RESULT_OUT :
                MEMWB_REGWRITE && MEMWB_ARD != 5'd0 && MEMWB_ARD == ARS1_IN ? MEMWB_RESULT : RS1_IN;
  assign rs2_f = REGWRITE_OUT && ARD_OUT != 5'd0 && ARD_OUT == ARS2_IN ? ALU_RESULT_OUT :
                 MEMWB_REGWRITE && MEMWB_ARD != 5'd0 && MEMWB_ARD == ARS2_IN ? MEMWB_RESULT : RS2_IN;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ARS1_IN, ARS2_IN, MEMWB_REGWRITE, MEMWB_ARD, MEMWB_RESULT};
  assign a_op = RS1_IN;
  assign rs2_f = RS2_IN;
`endif
  assign b_op = ALUSRC_IN ? IMMEDIATE_IN : rs2_f;
  assign ctl_in = {ARD_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN};
  assign start = !busy && !done && ALUOP_IN == MUL_OP;
  assign STALL = rst && (start || busy);
  always_comb begin
    alu = a_op + b_op;
    case (aluop_t'(ALUOP_IN))
      ALU_SUB:  alu = a_op - b_op;
      ALU_AND:  alu = a_op & b_op;
      ALU_OR:   alu = a_op | b_op;
      ALU_XOR:  alu = a_op ^ b_op;
      ALU_SLL:  alu = a_op << b_op[4:0];
      ALU_SRL:  alu = a_op >> b_op[4:0];
      ALU_SRA:  alu = $signed(a_op) >>> b_op[4:0];
      ALU_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(a_op) < $signed(b_op)};
      ALU_SLTU: alu = {{(WIDTH-1){1'b0}}, a_op < b_op};
      default:  alu = a_op + b_op;
    endcase
  end
  ex_mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a_op),
    .b(b_op),
    .busy(busy),
    .done(done),
    .product(product)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      {ALU_RESULT_OUT, STORE_DATA_OUT, ARD_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT} <= '0;
      {sd_q, ctl_q} <= '0;
    end else begin
      {ALU_RESULT_OUT, STORE_DATA_OUT, ARD_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT} <=
        done ? {product, sd_q, ctl_q} : start || busy ? '0 : {alu, rs2_f, ctl_in};
      if (start) {sd_q, ctl_q} <= {rs2_f, ctl_in};
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline. It consumes the ID/EX register outputs and produces the EX/MEM register outputs, held in internal flops.
- Contains:
  - operand forwarding from its own EX/MEM outputs and from MEM/WB;
  - a single-cycle ALU;
  - a 32-iteration shift-add multiplier FSM that stalls the front of the pipeline while it runs.

Parameters:
- WIDTH, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- ALUOP_IN  in  4  operation from ID/EX.
- ALUSRC_IN  in  1  1 selects IMMEDIATE_IN as operand B.
- REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN  in  1 each  control, passed through.
- ARS1_IN, ARS2_IN, ARD_IN  in  5 each  register addresses.
- RS1_IN, RS2_IN, IMMEDIATE_IN  in  WIDTH each  operand values.
- MEMWB_REGWRITE  in  1  MEM/WB write enable.
- MEMWB_ARD  in  5  MEM/WB destination.
- MEMWB_RESULT  in  WIDTH  MEM/WB writeback value.
- ALU_RESULT_OUT  out  WIDTH  EX/MEM result.
- STORE_DATA_OUT  out  WIDTH  forwarded rs2 for stores.
- ARD_OUT  out  5  EX/MEM destination.
- REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT  out  1 each  EX/MEM control.
- STALL  out  1  holds PC, IF/ID and ID/EX while high.

Behaviour:
- Reset: while rst==0 at an edge, every registered output goes to 0, FSM goes to IDLE and the counter clears. STALL is 0 during reset. Reset mid-multiply abandons the operation; no result is written.
- Forwarding, per operand A (rs1) and rs2:
  - Priority 1: EX/MEM, used if REGWRITE_OUT && ARD_OUT!=0 && ARD_OUT==ARSx_IN. Source is ALU_RESULT_OUT.
  - Priority 2: MEM/WB, same test with MEMWB_* signals.
  - Otherwise RSx_IN.
  - Address 0 never forwards.
- Operand B = IMMEDIATE_IN if ALUSRC_IN, else forwarded rs2. STORE_DATA_OUT always takes forwarded rs2.
- ALUOP encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0].
  - 1000 SLT (signed), 1001 SLTU; both write 0/1.
  - 1010 MUL, low WIDTH bits of the unsigned product, multi-cycle.
  - 1011–1111 behave as ADD.
  - All arithmetic wraps modulo 2^WIDTH.
- Single-cycle ops: latency 1. Edge N samples the inputs; EX/MEM outputs are valid after edge N. STALL stays 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if ALUOP_IN==MUL, STALL=1 (combinational). At the edge, latch forwarded A and B plus the control/ARD, clear the accumulator, counter=0, go to BUSY. The EX/MEM outputs load a bubble (all control 0, ARD 0, data 0).
  - BUSY: STALL=1. Each edge: if B[0], acc+=A; then A<<=1, B>>=1, counter++. The edge with counter==MUL_CYCLES-1 goes to DONE. EX/MEM keeps loading bubbles.
  - DONE: STALL=0. At the edge, EX/MEM loads acc with the latched control/ARD, then go to IDLE. DONE never retriggers on the still-present MUL inputs.
  - Total timing: STALL is high for MUL_CYCLES+1 cycles, and the result appears MUL_CYCLES+2 edges after the MUL is first presented.
- Back-to-back MULs: the second MUL is presented in the cycle after DONE and starts normally.
- The forwarding check during DONE uses the bubble in EX/MEM, so it never self-forwards.

Optional Feature:
- EX_FWD_EN defined: forwarding exactly as described above.
- EX_FWD_EN undefined: operand A = RS1_IN and rs2 = RS2_IN, with no forwarding logic. Software or the hazard unit must insert NOPs.

Decomposition:
- Package ex_pkg holds:
  - aluop_t enum with the 4-bit encodings above;
  - ex_state_t enum {IDLE, BUSY, DONE};
  - localparam MUL_OP = 4'b1010.
- One natural sub-module: ex_mul_seq, the iterative multiplier. Interface: start, a, b, busy, done, product. It contains the counter and the shift registers.
- Forwarding mux and ALU stay in ex_stage.

Test Plan:
- Reset: rst=0 for 1 edge with nonzero inputs -> all outputs 0, STALL=0.
- ADD with immediate: ALUOP=0000, ALUSRC=1, RS1=32'h0000_0010, IMM=32'h0000_0005, ARD=3, REGWRITE=1 -> after 1 edge ALU_RESULT_OUT=32'h15, ARD_OUT=3, REGWRITE_OUT=1.
- EX/MEM forwarding: previous result 32'h15 to x3, then SUB with ARS1=3, RS1_IN=0, RS2=32'h5 -> 32'h10.
- MEM/WB forwarding with EX/MEM priority:
  - MEMWB_ARD=3, MEMWB_RESULT=32'h99, REGWRITE_OUT=1, ARD_OUT=3 -> EX/MEM value is used.
  - With REGWRITE_OUT=0 -> 32'h99 is used.
  - With ARS1=0 -> RS1_IN is used.
- MUL: A=32'h0001_0003, B=32'h0000_0007 -> STALL high 33 cycles, then ALU_RESULT_OUT=32'h0007_0015. Bubbles appear on the outputs meanwhile.
- Mid-multiply reset: rst=0 during BUSY -> STALL drops, outputs 0, no result appears. A subsequent ADD works in 1 cycle.
